// File: rtl/ntru_pkg.sv
// ntru_pkg: shared NTRU multiplier defaults, width helper, r encoding
// and the loader state type.
package ntru_pkg;

    localparam int N_DEF = 541;
    localparam int Q_DEF = 2048;
    localparam int P_DEF = 3;

    // Bit-length of x: number of bits needed to hold the value x.
    function automatic int clog2(input int x);
        int b;
        b = 0;
        for (int i = 0; i < 31; i++) begin
            if ((x >> i) != 0) begin
                b = i + 1;
            end
        end
        return b;
    endfunction

    localparam int WH = clog2(Q_DEF - 1);
    localparam int WR = clog2(P_DEF - 1);

    localparam logic [1:0] R_ZERO = 2'd0;
    localparam logic [1:0] R_POS  = 2'd1;
    localparam logic [1:0] R_NEG  = 2'd2;

    typedef enum logic [2:0] {
        LOAD_H = 3'd0,
        LOAD_R = 3'd1,
        ARM    = 3'd2,
        RUN    = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/ntru_load_ctrl_if.sv
// ntru_load_ctrl_if: AXI4-Stream coefficient channel into the loader.
// master drives data/valid/last, slave returns ready.
interface ntru_load_ctrl_if #(
    parameter int TW = 16
);
    logic [TW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/ntru_coef_unpack.sv
// ntru_coef_unpack: splits a stream word into the h field or the ternary
// r code, flags nonzero r and out-of-range words.
module ntru_coef_unpack
    import ntru_pkg::*;
#(
    parameter int TW = 16,
    parameter int HW = 11,
    parameter int RW = 2
) (
    input  logic [TW-1:0] i_tdata,
    input  logic          i_is_r,
    output logic [HW-1:0] o_h,
    output logic [RW-1:0] o_r,
    output logic          o_nz,
    output logic          o_bad
);

    logic [RW-1:0] w_code;
    logic          w_hi_h;
    logic          w_hi_r;
    logic          w_inv;

    // Field extraction; the unused r code is folded to zero.
    always_comb begin
        w_code = i_tdata[RW-1:0];
        w_hi_h = |(i_tdata >> HW);
        w_hi_r = |(i_tdata >> RW);
        w_inv  = (w_code != RW'(R_ZERO))
              && (w_code != RW'(R_POS))
              && (w_code != RW'(R_NEG));
        o_h    = i_tdata[HW-1:0];
        o_r    = w_inv ? RW'(R_ZERO) : w_code;
        o_nz   = !w_inv && (w_code != RW'(R_ZERO));
        o_bad  = i_is_r ? (w_hi_r || w_inv) : w_hi_h;
    end

endmodule

// File: rtl/ntru_load_ctrl.sv
// ntru_load_ctrl: loads h then r from one AXI4-Stream into the multiplier
// memories, counts nonzero r, then requests start. Option: NTRU_LOAD_CHECK_EN.
module ntru_load_ctrl
    import ntru_pkg::*;
#(
    parameter  int N  = N_DEF,
    parameter  int q  = Q_DEF,
    parameter  int p  = P_DEF,
    parameter  int TW = 16,
    localparam int AW = clog2(N - 1),
    localparam int HW = clog2(q - 1),
    localparam int RW = clog2(p - 1),
    localparam int CW = clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    ntru_load_ctrl_if.slave s_axis,
    output logic            h_we,
    output logic [AW-1:0]   h_addr,
    output logic [HW-1:0]   h_din,
    output logic            r_we,
    output logic [AW-1:0]   r_addr,
    output logic [RW-1:0]   r_din,
    output logic [CW-1:0]   nnz,
    output logic            start_op,
    input  logic            end_op,
    output logic            err
);

    state_t        r_state;
    logic [AW-1:0] r_cnt;
    logic          r_h_we;
    logic [AW-1:0] r_h_addr;
    logic [HW-1:0] r_h_din;
    logic          r_r_we;
    logic [AW-1:0] r_r_addr;
    logic [RW-1:0] r_r_din;
    logic [CW-1:0] r_nnz;

    logic          w_ready;
    logic          w_hs;
    logic          w_is_r;
    logic          w_last_cnt;
    logic [HW-1:0] w_h;
    logic [RW-1:0] w_r;
    logic          w_nz;
    logic          w_bad;

    ntru_coef_unpack #(
        .TW (TW),
        .HW (HW),
        .RW (RW)
    ) u_unpack (
        .i_tdata (s_axis.tdata),
        .i_is_r  (w_is_r),
        .o_h     (w_h),
        .o_r     (w_r),
        .o_nz    (w_nz),
        .o_bad   (w_bad)
    );

    // Handshake qualifiers derived from the current state and beat count.
    always_comb begin
        w_ready    = (r_state == LOAD_H) || (r_state == LOAD_R);
        w_is_r     = (r_state == LOAD_R);
        w_hs       = s_axis.tvalid && w_ready;
        w_last_cnt = (r_cnt == AW'(N - 1));
    end

    assign s_axis.tready = w_ready;
    assign start_op      = (r_state == RUN);

    // Load sequencing: beat counter per polynomial and phase transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOAD_H;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                LOAD_H: begin
                    if (w_hs) begin
                        if (w_last_cnt) begin
                            r_cnt   <= '0;
                            r_state <= LOAD_R;
                        end else begin
                            r_cnt <= r_cnt + AW'(1);
                        end
                    end
                end
                LOAD_R: begin
                    if (w_hs) begin
                        if (w_last_cnt) begin
                            r_cnt   <= '0;
                            r_state <= ARM;
                        end else begin
                            r_cnt <= r_cnt + AW'(1);
                        end
                    end
                end
                ARM: begin
                    r_state <= RUN;
                end
                RUN: begin
                    if (end_op) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= DONE;
                end
                default: begin
                    r_state <= LOAD_H;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Registered memory write ports: one strobe cycle per accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_we   <= 1'b0;
            r_h_addr <= '0;
            r_h_din  <= '0;
            r_r_we   <= 1'b0;
            r_r_addr <= '0;
            r_r_din  <= '0;
        end else begin
            r_h_we <= w_hs && !w_is_r;
            r_r_we <= w_hs && w_is_r;
            if (w_hs && !w_is_r) begin
                r_h_addr <= r_cnt;
                r_h_din  <= w_h;
            end
            if (w_hs && w_is_r) begin
                r_r_addr <= r_cnt;
                r_r_din  <= w_r;
            end
        end
    end

    // Nonzero r count, saturating at N; lands with the matching r write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nnz <= '0;
        end else if (w_hs && w_is_r && w_nz && (r_nnz != CW'(N))) begin
            r_nnz <= r_nnz + CW'(1);
        end
    end

    assign h_we   = r_h_we;
    assign h_addr = r_h_addr;
    assign h_din  = r_h_din;
    assign r_we   = r_r_we;
    assign r_addr = r_r_addr;
    assign r_din  = r_r_din;
    assign nnz    = r_nnz;

`ifdef NTRU_LOAD_CHECK_EN
    logic r_err;
    logic w_final;
    logic w_frame_bad;

    // The final beat of the frame is the last r coefficient.
    always_comb begin
        w_final     = w_is_r && w_last_cnt;
        w_frame_bad = (s_axis.tlast != w_final);
    end

    // Sticky error on framing or range violations; load carries on.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_hs && (w_bad || w_frame_bad)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    logic w_unused;

    assign w_unused = &{1'b0, s_axis.tlast, w_bad};
    assign err      = 1'b0;
`endif

endmodule

// File: doc/ntru_load_ctrl.md
# ntru_load_ctrl

Upstream loader for the NTRU serial multiplier. It accepts the public polynomial h and the ternary blinding polynomial r over one AXI4-Stream slave and writes them into the multiplier's h and r coefficient memories. While r streams in, it counts the nonzero coefficients of r and presents that count as `nnz`. Once both memories are full it holds `start_op` to the multiplier control until `end_op` returns.

## Interface
Parameters:
- `N`, 541: polynomial length (coefficients per polynomial).
- `q`, 2048: modulus of h. The h coefficient width is `WH = clog2(q-1)`, which is 11 at the default.
- `p`, 3: ternary modulus. The r coefficient width is `WR = clog2(p-1)`, which is 2.
- `TW`, 16: `s_axis_tdata` width; must be ≥ `WH`.

Ports:
- `clk` in 1: single clock; everything is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `s_axis_tdata` in `TW`: one coefficient per beat.
- `s_axis_tvalid` in 1: upstream data valid.
- `s_axis_tlast` in 1: upstream marks the final beat (beat 2N).
- `s_axis_tready` out 1: this block can accept a beat.
- `h_we` out 1: h memory write strobe.
- `h_addr` out `clog2(N-1)`: h memory write address.
- `h_din` out `WH`: h coefficient to write.
- `r_we` out 1: r memory write strobe.
- `r_addr` out `clog2(N-1)`: r memory write address.
- `r_din` out `WR`: r coefficient to write; 0 = zero, 1 = +1, 2 = −1.
- `nnz` out `clog2(N)`: count of nonzero r coefficients, to the multiplier control.
- `start_op` out 1: level request to the multiplier control to start.
- `end_op` in 1: multiplier finished; from the multiplier control.
- `err` out 1: sticky framing/range error flag.

## Operation
- FSM states: `LOAD_H` → `LOAD_R` → `ARM` → `RUN` → `DONE`.
- Reset enters `LOAD_H`.
- A handshake is `s_axis_tvalid && s_axis_tready`.
- `s_axis_tready` is 1 only in `LOAD_H` and `LOAD_R`.
- Beat counter `cnt` (width `clog2(N-1)`):
  - Counts handshakes 0..N-1 within each polynomial.
  - At N-1 it wraps to 0, and the state moves `LOAD_H`→`LOAD_R` or `LOAD_R`→`ARM`.
- h beat: `h_din = tdata[WH-1:0]`, `h_addr = cnt`.
- r beat:
  - `r_din = tdata[WR-1:0]`, `r_addr = cnt`.
  - `nnz` increments when `r_din` is 1 or 2. Code 3 is invalid: it is written as 0 and not counted.
  - `nnz` never exceeds N; the counter saturates.
- `ARM`: one cycle, so the final r write lands and `nnz` is final. Then the state moves to `RUN`.
- `RUN`:
  - `start_op` = 1.
  - When `end_op` = 1, `start_op` drops and the state moves to `DONE`.
- `DONE`:
  - `start_op` = 0 and `s_axis_tready` = 0.
  - Stays in `DONE` until `rst`, because the multiplier control's `end_op` is also cleared only by reset.
- Reset mid-load or mid-run: abandon the load. All counters, `nnz`, `err`, strobes and `start_op` clear to 0; state returns to `LOAD_H`.

## Timing
Reset values:
- `s_axis_tready` = 1, because `LOAD_H` is entered.
- `h_we`, `r_we`, `start_op`, `err` = 0.
- `nnz` = 0, `h_addr` / `r_addr` / `h_din` / `r_din` = 0.

Latency and ordering:
- Write outputs are registered. A handshake at cycle t gives `*_we`, address and data valid during cycle t+1, with the strobe high for exactly one cycle.
- `nnz` updates at t+1, together with the `r_we` of the same beat.
- `tvalid` gaps insert idle cycles; no write is issued for them.
- Back-to-back beats give one write per cycle.
- If the last r handshake is at t: `ARM` is t+1 (`r_we` high, final `nnz`), and `start_op` rises at t+2.
- `end_op` at cycle u: `start_op` is 0 at u+1.

Boundary cases:
- `end_op` high while not in `RUN` is ignored.
- Beats presented in `ARM`, `RUN` or `DONE` are stalled; `tready` = 0.

## Configuration
- `NTRU_LOAD_CHECK_EN` defined:
  - `err` sets, and stays set until `rst`, on any of:
    - `tlast` on a beat other than beat 2N;
    - `tlast` missing on beat 2N;
    - nonzero `tdata[TW-1:WH]` on an h beat;
    - nonzero `tdata[TW-1:WR]` on an r beat;
    - r code 3.
  - The load continues regardless.
- Not defined:
  - `err` is tied to 0 and `tlast` is ignored.
  - Upper `tdata` bits are discarded.
  - r code 3 is still written as 0 and not counted.

## Structure
- Package `ntru_pkg` holds:
  - the shared `N`, `q`, `p` defaults;
  - the `clog2` function (bit-length form, matching the multiplier control);
  - `WH` and `WR`;
  - the r encoding constants: `R_ZERO` = 0, `R_POS` = 1, `R_NEG` = 2;
  - the state enum.
- One sub-module, `ntru_coef_unpack`:
  - Combinational.
  - Extracts the h/r fields and produces `nz` (r nonzero) and `bad` (range violation).
- FSM, counters and registered write ports stay in `ntru_load_ctrl`.

## Test plan
- Reset, then 541 h beats (value = index mod 2048) and 541 r beats cycling 0, 1, 2, each with `tvalid` held high:
  - `h_we` fires 541 times, with `h_addr` 0..540;
  - `nnz` = 360 after the last `r_we`;
  - `start_op` rises 2 cycles after the last handshake.
- Same stream with `tvalid` toggled every other cycle: identical memory contents and `nnz`; no write in gap cycles.
- In `RUN`, pulse `end_op`:
  - `start_op` = 0 next cycle and `tready` stays 0;
  - a further `end_op` has no effect;
  - `rst` returns to `LOAD_H` with `nnz` = 0.
- With `NTRU_LOAD_CHECK_EN`:
  - `tlast` on beat 100 → `err` = 1 at the next cycle and stays 1;
  - r code 3 → written as 0, `nnz` unchanged;
  - without the macro, the same stimulus leaves `err` = 0.
- Assert `rst` in the middle of the r load (beat 800): all outputs return to reset values, and a fresh full load then yields the correct `nnz`.
